// File: rtl/cla_seq_adder_ctrl.sv
// Sequential adder: one 4-bit look-ahead slice reused over NIBBLES nibbles, LSB first.
// Define CLA_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module cla_seq_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
`ifdef CLA_SEQ_OVF_EN
  output logic                   ovf,
`endif
  output logic                   cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;

  logic [3:0]    a_n;
  logic [3:0]    b_n;
  logic [3:0]    p;
  logic [3:0]    g;
  logic [4:0]    c;
  logic [3:0]    s_n;
  logic          last;

  assign in_ready = (state_q == IDLE);
  assign last     = (idx_q == IW'(NIBBLES - 1));

  assign a_n = a_q[{idx_q, 2'b00} +: 4];
  assign b_n = b_q[{idx_q, 2'b00} +: 4];
  assign p   = a_n ^ b_n;
  assign g   = a_n & b_n;

  // Every carry is a two-level sum of products of p, g and c0.
  assign c[0] = carry_q;
  assign c[1] = g[0]
              | (p[0] & c[0]);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s_n  = p ^ c[3:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum[{idx_q, 2'b00} +: 4] <= s_n;
          carry_q <= c[4];
          idx_q   <= idx_q + IW'(1);
          if (last) begin
            idx_q     <= '0;
            cout      <= c[4];
            out_valid <= 1'b1;
`ifdef CLA_SEQ_OVF_EN
            ovf       <= c[3] ^ c[4];
`endif
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Bench for cla_seq_adder_ctrl (NIBBLES=4): directed table, corner
// sequences and randomized transactions against an arithmetic model.
module tb_cla_seq_adder_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CLA_SEQ_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_seq_adder_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CLA_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           stall;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction starting #1 after an edge with the DUT idle.
  // Meanwhile drives junk operands (and optionally in_valid) that must be ignored.
  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vc, input int stall,
                       input logic [W-1:0] es, input logic ec,
                       input logic eo, input bit junk, input string tag);
    int n;
    chk({tag, " in_ready idle"}, in_ready, 1);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk({tag, " in_ready busy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, n, N);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
`ifdef CLA_SEQ_OVF_EN
    chk({tag, " ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unreachable");
`endif
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, " hold valid"}, out_valid, 1);
      chk({tag, " hold sum"}, sum, es);
      chk({tag, " hold cout"}, cout, ec);
      chk({tag, " hold in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, " valid drop"}, out_valid, 0);
    chk({tag, " in_ready back"}, in_ready, 1);
    chk({tag, " sum kept"}, sum, es);
  endtask

  initial begin
    logic [W:0] full;
    logic [W-1:0] ra, rb;
    logic rc, rovf;
    int st;

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 2, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0});

    #1;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
`ifdef CLA_SEQ_OVF_EN
    chk("rst ovf", ovf, 0);
`endif
    #11 rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall,
            vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf,
            1'b0, $sformatf("vec%0d", i));

    // Backpressure with live in_valid and new operands during DONE.
    do_op(16'h00F0, 16'h0F10, 1'b0, 5, 16'h1000, 1'b0, 1'b0,
          1'b1, "bp");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp no capture ready", in_ready, 1);
      chk("bp no capture valid", out_valid, 0);
    end

    // Asynchronous reset two RUN cycles into an operation.
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst sum", sum, 0);
    chk("mid rst cout", cout, 0);
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst in_ready", in_ready, 1);
    #3 rst_n = 1'b1;
    tick();
    do_op(16'h0008, 16'h0008, 1'b0, 0, 16'h0010, 1'b0, 1'b0,
          1'b0, "post rst");

    // Randomized back-to-back transactions against plain arithmetic.
    for (int t = 0; t < 200; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      rovf = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
      do_op(ra, rb, rc, st, full[W-1:0], full[W], rovf,
            1'b1, $sformatf("rnd%0d", t));
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
